// File: rtl/muldiv_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit.
// MDOp encodings, FSM state type and default latencies.
package muldiv_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/muldiv_arith.sv
// Combinational datapath: next {HI,LO} from the latched op, operands and current {HI,LO}.
// MADD-class accumulate paths exist only when MULDIV_MADD_EN is defined.
module muldiv_arith
  import muldiv_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo,
  output logic [63:0] hilo_next
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes so 0x80000000 / -1 falls out naturally.
  assign sgn   = (op == MD_DIV);
  assign a_neg = sgn & a[31];
  assign b_neg = sgn & b[31];
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b + 32'd1) : b;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    hilo_next = hilo;
    case (op)
      MD_MULT:  hilo_next = prod_s;
      MD_MULTU: hilo_next = prod_u;
      MD_DIV,
      MD_DIVU:  hilo_next = (b == 32'd0) ? hilo : {rem, quot};
`ifdef MULDIV_MADD_EN
      MD_MADD:  hilo_next = hilo + prod_s;
      MD_MADDU: hilo_next = hilo + prod_u;
      MD_MSUB:  hilo_next = hilo - prod_s;
      MD_MSUBU: hilo_next = hilo - prod_u;
`endif
      default:  hilo_next = hilo;
    endcase
  end

endmodule

// File: rtl/execute_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the Execute stage.
// Define MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate operations.
module execute_muldiv
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  md_op_e      op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] hilo_next;
  md_op_e      op_in;

  assign op_in = md_op_e'(MDOp);

  muldiv_arith u_arith (
    .op        (op_q),
    .a         (a_q),
    .b         (b_q),
    .hilo      ({hi_q, lo_q}),
    .hilo_next (hilo_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (op_in)
            MD_MULT, MD_MULTU: begin
              op_d    = op_in;
              a_d     = A;
              b_d     = B;
              cnt_d   = 4'(MULT_CYCLES);
              state_d = S_RUN;
            end
`ifdef MULDIV_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
              op_d    = op_in;
              a_d     = A;
              b_d     = B;
              cnt_d   = 4'(MULT_CYCLES);
              state_d = S_RUN;
            end
`endif
            MD_DIV, MD_DIVU: begin
              op_d    = op_in;
              a_d     = A;
              b_d     = B;
              cnt_d   = 4'(DIV_CYCLES);
              state_d = S_RUN;
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Start is ignored here; the hazard unit keeps it from happening.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          {hi_d, lo_d} = hilo_next;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= MD_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
